// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module   : id_ex_stage
//  Purpose  : ID/EX pipeline register feeding the execute ALU. Captures the
//             decoded operands and control fields, resolves RAW hazards by
//             forwarding from EX/MEM and MEM/WB, and detects load-use
//             hazards so decode can be held while a bubble is inserted.
//
//  Build option:
//    ID_EX_FWD_EN  defined   -> forwarding network + load-use detection
//                  undefined -> operands come straight from the registered
//                               read data, load_use_stall_o tied 0 and
//                               bubble_count_o stays 0 (hazards are
//                               scheduled by software with NOPs)
//
//  Ports:
//    clk, rst_n                 clock (rising edge), async active-low reset
//    in_*_i                     decoded instruction from the ID stage
//    stall_i                    downstream hold (all fields hold)
//    flush_i                    kill the held instruction (beats stall)
//    exmem_* / memwb_*          producer destinations, enables and values
//    alu_a_o, alu_b_o, alu_sel_o ALU operands and operation select
//    ex_valid_o, ex_rd_addr_o   stage valid and destination register
//    ex_reg_we_o, ex_mem_re_o,
//    ex_mem_we_o                controls, forced 0 when the stage is empty
//    ex_store_data_o            forwarded rs2 value for stores
//    load_use_stall_o           decode must hold this cycle
//    bubble_count_o             saturating count of load-use bubbles
//
//  Revision : 1.0  initial release
// ============================================================================
module id_ex_stage #(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 4,
    parameter int SEL_W   = 3
) (
    input  logic                clk,
    input  logic                rst_n,

    input  logic                in_valid_i,
    input  logic [RADDR_W-1:0]  in_rs1_addr_i,
    input  logic [RADDR_W-1:0]  in_rs2_addr_i,
    input  logic [DATA_W-1:0]   in_rs1_data_i,
    input  logic [DATA_W-1:0]   in_rs2_data_i,
    input  logic [DATA_W-1:0]   in_imm_i,
    input  logic                in_use_imm_i,
    input  logic [SEL_W-1:0]    in_alu_sel_i,
    input  logic [RADDR_W-1:0]  in_rd_addr_i,
    input  logic                in_reg_we_i,
    input  logic                in_mem_re_i,
    input  logic                in_mem_we_i,

    input  logic                stall_i,
    input  logic                flush_i,

    input  logic [RADDR_W-1:0]  exmem_rd_i,
    input  logic                exmem_we_i,
    input  logic [DATA_W-1:0]   exmem_result_i,
    input  logic [RADDR_W-1:0]  memwb_rd_i,
    input  logic                memwb_we_i,
    input  logic [DATA_W-1:0]   memwb_result_i,

    output logic [DATA_W-1:0]   alu_a_o,
    output logic [DATA_W-1:0]   alu_b_o,
    output logic [SEL_W-1:0]    alu_sel_o,
    output logic                ex_valid_o,
    output logic [RADDR_W-1:0]  ex_rd_addr_o,
    output logic                ex_reg_we_o,
    output logic                ex_mem_re_o,
    output logic                ex_mem_we_o,
    output logic [DATA_W-1:0]   ex_store_data_o,
    output logic                load_use_stall_o,
    output logic [15:0]         bubble_count_o
);

    localparam logic [15:0]        c_BUBBLE_MAX = 16'hFFFF;
    localparam logic [RADDR_W-1:0] c_R0         = '0;

    // ------------------------------------------------------------------
    // Pipeline registers
    // ------------------------------------------------------------------
    logic                valid_q,    valid_d;
    logic [RADDR_W-1:0]  rs1_addr_q, rs1_addr_d;
    logic [RADDR_W-1:0]  rs2_addr_q, rs2_addr_d;
    logic [DATA_W-1:0]   rs1_data_q, rs1_data_d;
    logic [DATA_W-1:0]   rs2_data_q, rs2_data_d;
    logic [DATA_W-1:0]   imm_q,      imm_d;
    logic                use_imm_q,  use_imm_d;
    logic [SEL_W-1:0]    sel_q,      sel_d;
    logic [RADDR_W-1:0]  rd_q,       rd_d;
    logic                reg_we_q,   reg_we_d;
    logic                mem_re_q,   mem_re_d;
    logic                mem_we_q,   mem_we_d;
    logic [15:0]         bubble_q,   bubble_d;

    // Operand values after hazard resolution, and the load-use decision
    logic [DATA_W-1:0]   rs1_fwd;
    logic [DATA_W-1:0]   rs2_fwd;
    logic                load_use;

`ifdef ID_EX_FWD_EN
    // The newer producer (EX/MEM) wins over the older one (MEM/WB).
    // Register 0 is hard-wired to zero, so no producer may override it.
    always_comb begin
        rs1_fwd = rs1_data_q;
        if (rs1_addr_q == c_R0) begin
            rs1_fwd = '0;
        end else if (exmem_we_i && (exmem_rd_i == rs1_addr_q)) begin
            rs1_fwd = exmem_result_i;
        end else if (memwb_we_i && (memwb_rd_i == rs1_addr_q)) begin
            rs1_fwd = memwb_result_i;
        end
    end

    always_comb begin
        rs2_fwd = rs2_data_q;
        if (rs2_addr_q == c_R0) begin
            rs2_fwd = '0;
        end else if (exmem_we_i && (exmem_rd_i == rs2_addr_q)) begin
            rs2_fwd = exmem_result_i;
        end else if (memwb_we_i && (memwb_rd_i == rs2_addr_q)) begin
            rs2_fwd = memwb_result_i;
        end
    end

    // A load in EX has no value until MEM, so a dependent instruction in
    // decode cannot be served by forwarding next cycle. rs2 is only a real
    // dependency when the op reads it: register-register ops and stores
    // (the store data always comes from rs2, even with an immediate).
    logic w_rs2_used;
    logic w_rs1_hit;
    logic w_rs2_hit;

    assign w_rs2_used = ~in_use_imm_i | in_mem_we_i;
    assign w_rs1_hit  = (rd_q == in_rs1_addr_i);
    assign w_rs2_hit  = w_rs2_used & (rd_q == in_rs2_addr_i);

    assign load_use = valid_q & mem_re_q & (rd_q != c_R0) & in_valid_i
                    & (w_rs1_hit | w_rs2_hit);
`else
    assign rs1_fwd  = rs1_data_q;
    assign rs2_fwd  = rs2_data_q;
    assign load_use = 1'b0;

    // Producer ports and captured source addresses have no consumer when
    // forwarding is compiled out.
    logic w_unused_fwd;
    assign w_unused_fwd = ^{exmem_rd_i, exmem_we_i, exmem_result_i,
                            memwb_rd_i, memwb_we_i, memwb_result_i,
                            rs1_addr_q, rs2_addr_q};
`endif

    // ------------------------------------------------------------------
    // Next-state selection: flush > stall > load-use bubble > capture
    // ------------------------------------------------------------------
    always_comb begin
        valid_d    = valid_q;
        rs1_addr_d = rs1_addr_q;
        rs2_addr_d = rs2_addr_q;
        rs1_data_d = rs1_data_q;
        rs2_data_d = rs2_data_q;
        imm_d      = imm_q;
        use_imm_d  = use_imm_q;
        sel_d      = sel_q;
        rd_d       = rd_q;
        reg_we_d   = reg_we_q;
        mem_re_d   = mem_re_q;
        mem_we_d   = mem_we_q;
        bubble_d   = bubble_q;

        if (flush_i) begin
            // Data fields are left as-is; an invalid slot ignores them.
            valid_d  = 1'b0;
            reg_we_d = 1'b0;
            mem_re_d = 1'b0;
            mem_we_d = 1'b0;
        end else if (stall_i) begin
            // Hold the instruction, but fold in any producer value visible
            // now: that producer may retire before the stall releases, and
            // the register-file data captured at decode is already stale.
            rs1_data_d = rs1_fwd;
            rs2_data_d = rs2_fwd;
        end else if (load_use) begin
            valid_d  = 1'b0;
            reg_we_d = 1'b0;
            mem_re_d = 1'b0;
            mem_we_d = 1'b0;
            if (bubble_q != c_BUBBLE_MAX) begin
                bubble_d = bubble_q + 16'd1;
            end
        end else begin
            valid_d    = in_valid_i;
            rs1_addr_d = in_rs1_addr_i;
            rs2_addr_d = in_rs2_addr_i;
            rs1_data_d = in_rs1_data_i;
            rs2_data_d = in_rs2_data_i;
            imm_d      = in_imm_i;
            use_imm_d  = in_use_imm_i;
            sel_d      = in_alu_sel_i;
            rd_d       = in_rd_addr_i;
            reg_we_d   = in_valid_i & in_reg_we_i;
            mem_re_d   = in_valid_i & in_mem_re_i;
            mem_we_d   = in_valid_i & in_mem_we_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= 1'b0;
            rs1_addr_q <= '0;
            rs2_addr_q <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
            use_imm_q  <= 1'b0;
            sel_q      <= '0;
            rd_q       <= '0;
            reg_we_q   <= 1'b0;
            mem_re_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            bubble_q   <= '0;
        end else begin
            valid_q    <= valid_d;
            rs1_addr_q <= rs1_addr_d;
            rs2_addr_q <= rs2_addr_d;
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
            imm_q      <= imm_d;
            use_imm_q  <= use_imm_d;
            sel_q      <= sel_d;
            rd_q       <= rd_d;
            reg_we_q   <= reg_we_d;
            mem_re_q   <= mem_re_d;
            mem_we_q   <= mem_we_d;
            bubble_q   <= bubble_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign alu_a_o          = rs1_fwd;
    assign alu_b_o          = use_imm_q ? imm_q : rs2_fwd;
    assign alu_sel_o        = sel_q;
    assign ex_valid_o       = valid_q;
    assign ex_rd_addr_o     = rd_q;
    // Controls are cleared on every invalidating path already; the extra
    // gate keeps an empty slot from ever presenting a side effect.
    assign ex_reg_we_o      = valid_q & reg_we_q;
    assign ex_mem_re_o      = valid_q & mem_re_q;
    assign ex_mem_we_o      = valid_q & mem_we_q;
    assign ex_store_data_o  = rs2_fwd;
    assign load_use_stall_o = load_use;
    assign bubble_count_o   = bubble_q;

endmodule
`default_nettype wire

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register directly upstream of the execute ALU.
- Captures decoded operands and control, resolves data hazards by forwarding from EX/MEM and MEM/WB, and detects load-use hazards.
- Drives the ALU operand and op-select inputs (A, B, 3-bit sel) and carries destination/control fields toward EX/MEM.

Parameters:
- DATA_W, 32, operand/result width
- RADDR_W, 4, register-file address width; register 0 reads as zero
- SEL_W, 3, ALU op-select width (encodings 000..101)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  decode slot holds an instruction
- in_rs1_addr, in_rs2_addr  in  RADDR_W  source register addresses
- in_rs1_data, in_rs2_data  in  DATA_W  register-file read data
- in_imm  in  DATA_W  sign-extended immediate
- in_use_imm  in  1  B operand = immediate
- in_alu_sel  in  SEL_W  ALU operation
- in_rd_addr  in  RADDR_W  destination register
- in_reg_we, in_mem_re, in_mem_we  in  1  writeback / load / store controls
- stall  in  1  downstream hold
- flush  in  1  kill the instruction held in this stage
- exmem_rd, memwb_rd  in  RADDR_W  producer destinations
- exmem_we, memwb_we  in  1  producer write enables
- exmem_result, memwb_result  in  DATA_W  producer values
- alu_a, alu_b  out  DATA_W  ALU operands
- alu_sel  out  SEL_W  ALU op
- ex_valid  out  1  stage valid
- ex_rd_addr  out  RADDR_W
- ex_reg_we, ex_mem_re, ex_mem_we  out  1  gated by ex_valid
- ex_store_data  out  DATA_W  forwarded rs2 value
- load_use_stall  out  1  decode must hold
- bubble_count  out  16  count of inserted load-use bubbles, saturating

Behaviour:
- Reset (rst_n low, asynchronous): all registers 0.
  - ex_valid=0, alu_sel=000, alu_a=alu_b=0, all controls 0, bubble_count=0.
  - load_use_stall=0.
- Register update priority per rising edge:
  - flush: ex_valid<=0, other fields don't-care; controls forced 0. Flush beats stall.
  - else stall: hold all fields. Each held rs1/rs2 data register is overwritten with its current forwarded value, so a producer retiring during the stall is not lost.
  - else load_use_stall: insert bubble (ex_valid<=0); bubble_count increments, saturating at 0xFFFF.
  - else: capture all in_* fields; ex_valid<=in_valid.
- Forwarding (combinational on registered rs data), per source:
  - EX/MEM match (exmem_we and exmem_rd==rs and rs!=0) takes priority.
  - else MEM/WB match.
  - else the registered value.
  - rs==0 always yields 0.
- alu_a = fwd(rs1).
- alu_b = in_use_imm captured ? imm : fwd(rs2).
- ex_store_data = fwd(rs2) regardless of immediate use.
- load_use_stall = ex_valid & ex_mem_re & ex_rd_addr!=0 & in_valid, and ex_rd_addr equals in_rs1_addr or in_rs2_addr. in_rs2_addr counts only when the decoded op uses rs2 (not in_use_imm, or in_mem_we).
- Latency: one cycle from decode inputs to ALU inputs; forwarding adds no cycles.
- ex_reg_we/ex_mem_re/ex_mem_we are 0 whenever ex_valid=0.
- Reset asserted mid-stall clears everything; no held instruction survives.

Optional Feature:
- Macro ID_EX_FWD_EN.
- Defined: forwarding network and load-use detection as above.
- Undefined:
  - alu_a/alu_b/ex_store_data come straight from registered data.
  - load_use_stall tied 0; bubble_count stays 0.
  - Software schedules hazards with NOPs.

Test Plan:
- Reset: rst_n low mid-cycle with ex_valid=1 -> all outputs 0 immediately, before any clock edge.
- Plain capture: in rs1_data=7, rs2_data=5, sel=001, rd=3, valid=1 -> next cycle alu_a=7, alu_b=5, alu_sel=001, ex_rd_addr=3, ex_valid=1.
- Dual forward priority: exmem_rd=2/exmem_result=100 and memwb_rd=2/memwb_result=50, rs1=2 -> alu_a=100. With exmem_we=0 -> alu_a=50. rs1=0 with rd=0 producers -> alu_a=0.
- Load-use: EX holds load rd=4, decode rs2=4 with in_use_imm=0 -> load_use_stall=1; next cycle ex_valid=0 and bubble_count=1. Repeat with in_use_imm=1 and no store -> no stall.
- Stall refresh: stall=1 for 3 cycles while memwb writes rs1 (=9) then retires -> after stall drops, alu_a still 9.
- Flush vs stall: flush=1 and stall=1 same edge -> ex_valid=0 and ex_reg_we=0 next cycle.
